// File: rtl/bht_resolve_unit.sv
// bht_resolve_unit: 2-bit saturating-counter BHT updated from resolved branches, with flush sweep and mispredict counter
module bht_resolve_unit #(
   parameter int NR_ENTRIES = 64,
   parameter int VLEN       = 39,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 flush_i,
   input  logic                 debug_mode_i,
   input  logic [VLEN-1:0]      vpc_i,
   input  logic                 resolve_valid_i,
   input  logic [VLEN-1:0]      resolve_pc_i,
   input  logic                 resolve_is_branch_i,
   input  logic                 resolve_taken_i,
   input  logic                 resolve_mispredict_i,
   output logic                 predict_valid_o,
   output logic                 predict_taken_o,
   output logic                 busy_o,
   output logic [CNT_WIDTH-1:0] mispredict_cnt_o
);
   localparam int IDX = $clog2(NR_ENTRIES);
   typedef enum logic {IDLE, FLUSH} state_t;
   state_t state, state_next;
   logic [IDX-1:0] sweep, upd_idx, p_idx;
   logic upd_valid, upd_taken, capture, do_update, do_clear;
   logic [NR_ENTRIES-1:0] valid;
   logic [NR_ENTRIES-1:0][1:0] cnt;
   logic [1:0] old_cnt, new_cnt;
   logic [CNT_WIDTH-1:0] mis_cnt;
   logic unused;
   // Tags are not stored, so the PC bits outside the index are intentionally ignored
   assign unused = ^{vpc_i[VLEN-1:IDX+1], vpc_i[0], resolve_pc_i[VLEN-1:IDX+1], resolve_pc_i[0]};
   assign p_idx = vpc_i[IDX:1];
   assign capture = resolve_valid_i & resolve_is_branch_i & ~debug_mode_i & (state == IDLE) & ~flush_i;
   assign do_update = upd_valid & (state == IDLE) & ~flush_i;
   assign do_clear = (state == FLUSH) & ~flush_i;
   assign old_cnt = cnt[upd_idx];
   assign mispredict_cnt_o = mis_cnt;
   // Saturating counter step for the entry addressed by the registered update
   always_comb begin
      new_cnt = !valid[upd_idx] ? (upd_taken ? 2'b10 : 2'b01) :
                upd_taken ? (old_cnt == 2'b11 ? old_cnt : old_cnt + 2'b01) :
                (old_cnt == 2'b00 ? old_cnt : old_cnt - 2'b01);
   end
   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else state <= state_next;
   end
   // Next state: flush (re)starts the sweep, last swept entry returns to idle
   always_comb begin
      state_next = flush_i ? FLUSH :
                   (state == FLUSH && sweep == IDX'(NR_ENTRIES - 1)) ? IDLE : state;
   end
   // Outputs: predictions are masked while the sweep runs
   always_comb begin
      busy_o = (state == FLUSH);
      predict_valid_o = (state == IDLE) & valid[p_idx];
      predict_taken_o = (state == IDLE) & valid[p_idx] & cnt[p_idx][1];
   end
   // Sweep index and stage-0 update register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sweep <= '0;
         upd_valid <= 1'b0;
         upd_idx <= '0;
         upd_taken <= 1'b0;
      end else begin
         sweep <= flush_i ? '0 : (state == FLUSH ? sweep + IDX'(1) : sweep);
         upd_valid <= capture;
         if (capture) begin
            upd_idx <= resolve_pc_i[IDX:1];
            upd_taken <= resolve_taken_i;
         end
      end
   end
   // Table array: sweep clears one entry per cycle, otherwise stage-1 writes the update
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid <= '0;
         cnt <= '0;
      end else if (do_clear) begin
         valid[sweep] <= 1'b0;
         cnt[sweep] <= 2'b00;
      end else if (do_update) begin
         valid[upd_idx] <= 1'b1;
         cnt[upd_idx] <= new_cnt;
      end
   end
   // Mispredict counter saturates at all-ones and survives flushes
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) mis_cnt <= '0;
      else if (resolve_valid_i & resolve_mispredict_i & ~&mis_cnt) mis_cnt <= mis_cnt + CNT_WIDTH'(1);
   end
endmodule

// File: tb/tb_bht_resolve_unit.sv
// tb_bht_resolve_unit: directed-vector bench for bht_resolve_unit
module tb_bht_resolve_unit;
   logic clk = 1'b0, rst = 1'b1, flush = 1'b0, dbg = 1'b0;
   logic [38:0] vpc = '0, rpc = '0;
   logic rvalid = 1'b0, rbr = 1'b0, rtaken = 1'b0, rmis = 1'b0;
   logic pv, pt, busy;
   logic [3:0] mcnt;
   int n_vec = 0, n_err = 0;
   bht_resolve_unit #(.NR_ENTRIES(64), .VLEN(39), .CNT_WIDTH(4)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .debug_mode_i(dbg), .vpc_i(vpc),
      .resolve_valid_i(rvalid), .resolve_pc_i(rpc), .resolve_is_branch_i(rbr),
      .resolve_taken_i(rtaken), .resolve_mispredict_i(rmis),
      .predict_valid_o(pv), .predict_taken_o(pt), .busy_o(busy), .mispredict_cnt_o(mcnt)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic report(input logic [38:0] pc, input logic tk, input logic br, input logic mis, input logic d);
      rvalid = 1'b1; rpc = pc; rtaken = tk; rbr = br; rmis = mis; dbg = d;
      step();
      rvalid = 1'b0; rbr = 1'b0; rtaken = 1'b0; rmis = 1'b0; dbg = 1'b0;
   endtask
   initial begin
      int n, bad;
      #12;
      check("reset_pv", 32'(pv), 0);
      check("reset_pt", 32'(pt), 0);
      check("reset_busy", 32'(busy), 0);
      check("reset_cnt", 32'(mcnt), 0);
      step();
      rst = 1'b0;
      vpc = 39'h80000010;
      report(39'h80000010, 1, 1, 0, 0);
      check("first_pre_write_pv", 32'(pv), 0);
      step();
      check("first_pv", 32'(pv), 1);
      check("first_pt", 32'(pt), 1);
      for (int i = 0; i < 3; i++) report(39'h80000010, 1, 1, 0, 0);
      step();
      check("sat_hi_pt", 32'(pt), 1);
      report(39'h80000010, 0, 1, 0, 0);
      step();
      check("nt1_pt", 32'(pt), 1);
      report(39'h80000010, 0, 1, 0, 0);
      step();
      check("nt2_pt", 32'(pt), 0);
      check("nt2_pv", 32'(pv), 1);
      vpc = 39'h80000020;
      report(39'h80000020, 1, 1, 1, 1);
      step();
      check("debug_pv", 32'(pv), 0);
      check("debug_mcnt", 32'(mcnt), 1);
      report(39'h80000020, 1, 0, 1, 0);
      step();
      check("nonbr_pv", 32'(pv), 0);
      check("nonbr_mcnt", 32'(mcnt), 2);
      for (int i = 0; i < 64; i++) report(39'(i * 2), 1, 1, 0, 0);
      step();
      vpc = 39'd0;
      #1 check("pop_lo_pv", 32'(pv), 1);
      vpc = 39'd126;
      #1 check("pop_hi_pt", 32'(pt), 1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      n = 0;
      bad = 0;
      while (busy && n < 300) begin
         if (pv || pt) bad++;
         rvalid = (n == 10); rbr = (n == 10); rtaken = 1'b1; rpc = 39'h10;
         n++;
         step();
      end
      rvalid = 1'b0; rbr = 1'b0; rtaken = 1'b0;
      check("sweep_len", 32'(n), 64);
      check("sweep_masked", 32'(bad), 0);
      step();
      bad = 0;
      for (int i = 0; i < 64; i++) begin
         vpc = 39'(i * 2);
         #1 if (pv) bad++;
      end
      check("post_sweep_valid", 32'(bad), 0);
      report(39'h30, 1, 1, 0, 0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      vpc = 39'd126;
      n = 0;
      while (busy && n < 300) begin
         flush = (n == 29);
         n++;
         step();
      end
      flush = 1'b0;
      check("restart_len", 32'(n), 94);
      vpc = 39'h30;
      #1 check("discard_pv", 32'(pv), 0);
      for (int i = 0; i < 10; i++) report(39'h0, 0, 0, 1, 0);
      check("mcnt_12", 32'(mcnt), 12);
      for (int i = 0; i < 10; i++) report(39'h0, 0, 0, 1, 0);
      check("mcnt_sat", 32'(mcnt), 15);
      report(39'h80000010, 1, 1, 0, 0);
      step();
      vpc = 39'h80000010;
      #1 check("pre_rst_pv", 32'(pv), 1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      step();
      step();
      check("mid_sweep_busy", 32'(busy), 1);
      #2 rst = 1'b1;
      #1;
      check("async_busy", 32'(busy), 0);
      check("async_mcnt", 32'(mcnt), 0);
      check("async_pv", 32'(pv), 0);
      step();
      rst = 1'b0;
      step();
      check("post_rst_pv", 32'(pv), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/bht_resolve_unit.md
Name: bht_resolve_unit

Overview:
- Frontend-side consumer of resolved-branch reports issued by the execute-stage branch unit.
- Keeps a direct-mapped branch history table (BHT) of 2-bit saturating counters.
- Updates the table from resolved conditional branches and answers combinational taken/not-taken lookups for the fetch PC.
- Supports a multi-cycle table-clear sweep on flush, plus a saturating mispredict counter for performance monitoring.

Parameters:
NR_ENTRIES, 64, number of BHT entries; power of two, minimum 4
VLEN, 39, virtual address width
CNT_WIDTH, 16, width of mispredict performance counter

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous reset, active-high
flush_i  input  1  start table-clear sweep
debug_mode_i  input  1  core in debug mode; updates suppressed
vpc_i  input  VLEN  fetch PC to predict
resolve_valid_i  input  1  resolved-branch report valid
resolve_pc_i  input  VLEN  PC of resolved instruction
resolve_is_branch_i  input  1  report is a conditional branch (cf_type == Branch)
resolve_taken_i  input  1  actual branch outcome
resolve_mispredict_i  input  1  report flagged as mispredicted
predict_valid_o  output  1  table entry for vpc_i is valid
predict_taken_o  output  1  predicted taken
busy_o  output  1  clear sweep in progress
mispredict_cnt_o  output  CNT_WIDTH  saturating count of mispredicted reports

Behaviour:
- Reset and clock: one clock, clk_i. rst_i is asynchronous, active-high.
- Index: IDX = log2(NR_ENTRIES). Index for both lookup and update = pc[IDX:1] (halfword granularity). Tags are not stored; aliasing is accepted.
- Entry: {valid, cnt[1:0]}.
  - Reset: all valid=0, cnt=2'b00.
  - predict_valid_o = entry.valid.
  - predict_taken_o = entry.valid & cnt[1].
- Lookup: purely combinational from vpc_i. During FLUSH state both predict outputs are forced to 0.
- Update pipeline:
  - Stage 0: at edge E, the update register captures {pc, taken} when resolve_valid_i & resolve_is_branch_i & ~debug_mode_i & state==IDLE & ~flush_i. Otherwise its valid bit clears.
  - Stage 1: at edge E+1 the registered update is written to the array. A lookup first sees it in the cycle after E+1.
  - No read-after-write bypass. A lookup of the index being written in the same cycle returns the old value.
- Counter update rule:
  - Entry invalid: write valid=1, cnt = taken ? 2'b10 : 2'b01.
  - Entry valid, taken: cnt = min(cnt+1, 3).
  - Entry valid, not taken: cnt = max(cnt-1, 0).
- Back-to-back updates to the same index on consecutive cycles must each see the prior write. The array is written at stage 1, and the array read for the update happens in stage 1, so no hazard exists.
- FSM states: IDLE, FLUSH.
  - IDLE→FLUSH on flush_i. Sweep index reset to 0; any pending stage-1 update is discarded.
  - In FLUSH: clear the entry at the sweep index (valid=0, cnt=0) each cycle, then increment the index.
  - After clearing NR_ENTRIES-1, go to IDLE. The sweep lasts exactly NR_ENTRIES cycles.
  - flush_i asserted while in FLUSH restarts the sweep at index 0.
  - busy_o = (state==FLUSH), registered, reset 0.
- Mispredict counter:
  - Increments by 1 on each cycle with resolve_valid_i & resolve_mispredict_i, regardless of cf type, debug mode or flush state.
  - Saturates at all-ones; does not wrap.
  - Cleared only by rst_i, not by flush_i.
- Reset mid-operation: rst_i in any state forces IDLE, busy_o=0, all entries invalid, update register invalid, counter 0.
- Reset values of outputs: predict_valid_o=0, predict_taken_o=0, busy_o=0, mispredict_cnt_o=0.

Test Plan:
- Reset, then a taken branch report at pc 0x80000010 → lookup of 0x80000010 shows valid=1, taken=1 (cnt=2) two edges later. Before that it shows valid=0.
- Four taken reports, then two not-taken reports, same pc → cnt goes 2,3,3,3 then 2,1; after the last update predict_taken_o=0.
- Report while debug_mode_i=1, or with resolve_is_branch_i=0 → table unchanged. mispredict_cnt_o still increments if resolve_mispredict_i=1.
- Populate entries 0..63, pulse flush_i → busy_o=1 for exactly 64 cycles and predictions read 0 throughout. Afterwards all lookups show valid=0. A report issued during the sweep is dropped.
- Update at edge E immediately followed by flush_i → pending update is discarded and the entry remains invalid after the sweep. A second flush_i mid-sweep (cycle 30) extends busy_o to 30+64 cycles.
- CNT_WIDTH=4, 20 mispredict reports → mispredict_cnt_o saturates at 15. Assert rst_i mid-sweep → counter=0, busy_o=0 asynchronously.
